pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control-side driver for the `program_counter`. Accepts branch-type commands over a valid/ready handshake.
- Drives `pc_op` and the load target into the PC.
- Keeps a return-address stack: captures the PC's `pcinc` on CALL and supplies it back as the target on RET.
- Sits between the instruction decode/control logic and the `program_counter` in `top`.

Parameters:
- ANCHO, 16, width of PC addresses and targets.
- DEPTH, 8, number of entries in the return-address stack (>=2).

Ports:
- clk_i  input  1  system clock, all state on rising edge
- rst_n_i  input  1  synchronous active-low reset
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  sequencer can accept a command this cycle
- cmd_i  input  3  command code (cmd_t)
- target_i  input  ANCHO  jump/call destination
- pcinc_i  input  ANCHO  PC+4 from program_counter (pcinc_o)
- pc_op_o  output  2  to program_counter pc_op_i
- pc_target_o  output  ANCHO  to program_counter pc_i
- depth_o  output  $clog2(DEPTH+1)  current stack occupancy
- error_o  output  1  sticky overflow/underflow (or misalign) flag

Behaviour:
- pc_op encoding (fixed):
  - 00 RESET (PC<=0)
  - 01 HOLD
  - 10 INC (PC<=PC+4)
  - 11 LOAD (PC<=pc_i)
- cmd_t encoding:
  - 000 STEP
  - 001 JUMP
  - 010 CALL
  - 011 RET
  - 100 STALL
  - 101 RESTART
  - 110/111 reserved, treated as STALL.
- Reset (rst_n_i=0 at an edge):
  - state<=INIT; pc_op_o<=00; pc_target_o<=0; depth_o<=0; error_o<=0.
  - Stack contents don't-care.
  - cmd_ready_o=0 while in INIT.
  - Reset mid-operation discards the stack and any in-flight op.
- FSM states: INIT, RUN, ERR.
- INIT:
  - Next edge -> RUN with pc_op_o<=01.
  - The PC therefore sees exactly one RESET op while rst_n_i is low, then HOLD.
- RUN:
  - cmd_ready_o=1. A command is accepted on any edge where cmd_valid_i & cmd_ready_o.
  - pc_op_o/pc_target_o are registered: the command accepted at edge N appears after edge N, and the PC updates at edge N+1.
  - With no accept, pc_op_o<=01 (HOLD), and pc_target_o holds its value.
- RUN commands:
  - STEP: op 10.
  - JUMP: op 11, target<=target_i.
  - CALL, not full: push pcinc_i, op 11, target<=target_i, depth+1.
  - CALL, full (depth==DEPTH): no push, op 01, error_o<=1, ->ERR.
  - RET, not empty: pop top, op 11, target<=popped value, depth-1.
  - RET, empty: op 01, error_o<=1, ->ERR.
  - STALL: op 01.
  - RESTART: op 00, depth<=0, target<=0, stay RUN.
- ERR:
  - cmd_ready_o=1; pc_op_o=01.
  - All commands are consumed and ignored except RESTART.
  - RESTART: op 00, depth<=0, error_o<=0, ->RUN.
- Stack: LIFO, top = entry depth-1.
  - A CALL immediately followed by a RET returns the just-pushed value; no bypass hazard, because the push is registered before the next accept.
- Arithmetic: no address arithmetic in this block. Targets pass through at ANCHO bits, unmodified.

Optional Feature:
- Macro PC_SEQ_ALIGN_CHECK_EN.
- Defined:
  - JUMP/CALL with target_i[1:0]!=0 is rejected: op 01, no push, error_o<=1, ->ERR.
  - A RET popping a misaligned value behaves the same way.
- Undefined: no alignment check; targets pass through unmodified.

Decomposition:
- Package pc_pkg holds:
  - pc_op_t enum (PC_RESET, PC_HOLD, PC_INC, PC_LOAD)
  - cmd_t enum
  - seq_state_t enum
  - The program_counter is expected to import the same pc_op_t.
- One sub-module, ret_stack:
  - Parameters ANCHO, DEPTH.
  - Ports: clk_i, rst_n_i, push_i, pop_i, data_i, data_o, depth_o, full_o, empty_o.
  - Push and pop are never asserted together by pc_sequencer.

Test Plan:
- Reset then STEP x3 -> pc_op_o sequence 00(reset), 01, 10, 10, 10; with program_counter attached, PC=0x000C.
- JUMP 0x0040, then CALL 0x0100 with pcinc_i=0x0044 -> depth_o=1; then RET -> pc_op_o=11, pc_target_o=0x0044, depth_o=0.
- DEPTH=8: nine consecutive CALLs -> the 9th gives pc_op_o=01, error_o=1, depth_o=8; STEP in ERR -> pc_op_o stays 01; RESTART -> pc_op_o=00, depth_o=0, error_o=0.
- RET from empty after reset -> error_o=1, pc_op_o=01.
- cmd_valid_i low for 5 cycles in RUN -> pc_op_o=01 each cycle and pc_target_o unchanged; assert rst_n_i=0 mid-sequence at depth_o=3 -> next cycle depth_o=0, pc_op_o=00.
- With PC_SEQ_ALIGN_CHECK_EN: JUMP 0x0042 -> error_o=1, pc_op_o=01. Without the macro -> pc_op_o=11, pc_target_o=0x0042.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program counter and its control-side sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_RESET = 2'b00,
        PC_HOLD  = 2'b01,
        PC_INC   = 2'b10,
        PC_LOAD  = 2'b11
    } pc_op_t;

    // Codes 110/111 are reserved and decoded as STALL by the sequencer.
    typedef enum logic [2:0] {
        CMD_STEP    = 3'b000,
        CMD_JUMP    = 3'b001,
        CMD_CALL    = 3'b010,
        CMD_RET     = 3'b011,
        CMD_STALL   = 3'b100,
        CMD_RESTART = 3'b101
    } cmd_t;

    typedef enum logic [1:0] {
        SEQ_INIT = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_ERR  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for pc_sequencer; top of stack is entry depth-1.
module ret_stack
    import pc_pkg::*;
#(
    parameter int ANCHO = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [ANCHO-1:0]             data_i,
    output logic [ANCHO-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [ANCHO-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic [DW-1:0]    top_w;

    assign top_w   = depth_q - DW'(1);
    assign data_o  = mem_q[top_w[AW-1:0]];
    assign depth_o = depth_q;
    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);

    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[depth_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Branch-command sequencer driving program_counter, with a return-address stack.
// Optional target alignment check enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ANCHO = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [2:0]                   cmd_i,
    input  logic [ANCHO-1:0]             target_i,
    input  logic [ANCHO-1:0]             pcinc_i,
    output logic [1:0]                   pc_op_o,
    output logic [ANCHO-1:0]             pc_target_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         error_o
);

`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    seq_state_t       state_q, state_d;
    pc_op_t           op_q, op_d;
    logic [ANCHO-1:0] tgt_q, tgt_d;
    logic             err_q, err_d;
    logic             push, pop, clear;
    logic             accept;
    logic             stk_full, stk_empty;
    logic [ANCHO-1:0] stk_top;
    logic             tgt_misaligned;
    logic             top_misaligned;

    assign cmd_ready_o    = (state_q != SEQ_INIT);
    assign accept         = cmd_valid_i & cmd_ready_o;
    assign tgt_misaligned = ALIGN_CHK && (target_i[1:0] != 2'b00);
    assign top_misaligned = ALIGN_CHK && (stk_top[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        op_d    = PC_HOLD;
        tgt_d   = tgt_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            SEQ_INIT: state_d = SEQ_RUN;
            SEQ_RUN: begin
                if (accept) begin
                    case (cmd_t'(cmd_i))
                        CMD_STEP: op_d = PC_INC;
                        CMD_JUMP: begin
                            if (tgt_misaligned) begin
                                err_d   = 1'b1;
                                state_d = SEQ_ERR;
                            end else begin
                                op_d  = PC_LOAD;
                                tgt_d = target_i;
                            end
                        end
                        CMD_CALL: begin
                            if (stk_full || tgt_misaligned) begin
                                err_d   = 1'b1;
                                state_d = SEQ_ERR;
                            end else begin
                                push  = 1'b1;
                                op_d  = PC_LOAD;
                                tgt_d = target_i;
                            end
                        end
                        CMD_RET: begin
                            if (stk_empty || top_misaligned) begin
                                err_d   = 1'b1;
                                state_d = SEQ_ERR;
                            end else begin
                                pop   = 1'b1;
                                op_d  = PC_LOAD;
                                tgt_d = stk_top;
                            end
                        end
                        CMD_RESTART: begin
                            op_d  = PC_RESET;
                            clear = 1'b1;
                            tgt_d = '0;
                        end
                        default: op_d = PC_HOLD;
                    endcase
                end
            end
            SEQ_ERR: begin
                if (accept && (cmd_t'(cmd_i) == CMD_RESTART)) begin
                    op_d    = PC_RESET;
                    clear   = 1'b1;
                    err_d   = 1'b0;
                    state_d = SEQ_RUN;
                end
            end
            default: state_d = SEQ_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= SEQ_INIT;
            op_q    <= PC_RESET;
            tgt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
        end
    end

    // RESTART empties the stack through its synchronous reset.
    ret_stack #(
        .ANCHO (ANCHO),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i & ~clear),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pcinc_i),
        .data_o  (stk_top),
        .depth_o (depth_o),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign pc_op_o     = op_q;
    assign pc_target_o = tgt_q;
    assign error_o     = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; expectations follow PC_SEQ_ALIGN_CHECK_EN when defined.
module tb_pc_sequencer;

    localparam int ANCHO = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    localparam logic [2:0] C_STEP = 3'd0, C_JUMP = 3'd1, C_CALL = 3'd2, C_RET = 3'd3,
                           C_STALL = 3'd4, C_RESTART = 3'd5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic [2:0]       cmd = '0;
    logic [ANCHO-1:0] tgt_in = '0;
    logic [ANCHO-1:0] pcinc = '0;
    logic             ready;
    logic [1:0]       op;
    logic [ANCHO-1:0] tgt_out;
    logic [DW-1:0]    dep;
    logic             err;
    logic [ANCHO-1:0] pc_r;

    typedef struct packed {
        logic             rdy;
        logic [1:0]       op;
        logic [ANCHO-1:0] tgt;
        logic [DW-1:0]    dep;
        logic             err;
    } obs_t;

    obs_t             sbq[$];
    int               m_state = 0;
    logic [1:0]       m_op = 2'b00;
    logic [ANCHO-1:0] m_tgt = '0;
    logic             m_err = 1'b0;
    logic [ANCHO-1:0] m_stk[$];
    int               checks = 0;
    int               errors = 0;

    pc_sequencer #(.ANCHO(ANCHO), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (valid),
        .cmd_ready_o (ready),
        .cmd_i       (cmd),
        .target_i    (tgt_in),
        .pcinc_i     (pcinc),
        .pc_op_o     (op),
        .pc_target_o (tgt_out),
        .depth_o     (dep),
        .error_o     (err)
    );

    always #5 clk = ~clk;

    // Minimal program_counter stand-in fed by the sequencer outputs.
    always @(posedge clk) begin
        case (op)
            2'b00: pc_r <= '0;
            2'b10: pc_r <= pc_r + 16'd4;
            2'b11: pc_r <= tgt_out;
            default: pc_r <= pc_r;
        endcase
    end

    function automatic string fmt(input obs_t v);
        return $sformatf("rdy=%0b op=%0d tgt=%h dep=%0d err=%0b", v.rdy, v.op, v.tgt, v.dep, v.err);
    endfunction

    // Drives one cycle, advances the reference model, and returns expected and observed.
    task automatic cyc(input logic r, input logic v, input logic [2:0] c,
                       input logic [ANCHO-1:0] t, input logic [ANCHO-1:0] pi,
                       output obs_t e, output obs_t o);
        obs_t x;
        rst_n = r; valid = v; cmd = c; tgt_in = t; pcinc = pi;
        #1;
        x.rdy = (m_state != 0);
        o.rdy = ready;
        if (!r) begin
            m_state = 0; m_op = 2'b00; m_tgt = '0; m_err = 1'b0; m_stk.delete();
        end else if (m_state == 0) begin
            m_state = 1; m_op = 2'b01;
        end else if (m_state == 1) begin
            m_op = 2'b01;
            if (v) begin
                case (c)
                    C_STEP: m_op = 2'b10;
                    C_JUMP: if (ALN && t[1:0] != 2'b00) begin m_err = 1'b1; m_state = 2; end
                            else begin m_op = 2'b11; m_tgt = t; end
                    C_CALL: if (m_stk.size() == DEPTH || (ALN && t[1:0] != 2'b00)) begin
                                m_err = 1'b1; m_state = 2;
                            end else begin
                                m_stk.push_back(pi); m_op = 2'b11; m_tgt = t;
                            end
                    C_RET: if (m_stk.size() == 0) begin m_err = 1'b1; m_state = 2; end
                           else if (ALN && m_stk[$][1:0] != 2'b00) begin m_err = 1'b1; m_state = 2; end
                           else begin m_op = 2'b11; m_tgt = m_stk.pop_back(); end
                    C_RESTART: begin m_op = 2'b00; m_stk.delete(); m_tgt = '0; end
                    default: m_op = 2'b01;
                endcase
            end
        end else begin
            m_op = 2'b01;
            if (v && c == C_RESTART) begin
                m_op = 2'b00; m_stk.delete(); m_err = 1'b0; m_state = 1;
            end
        end
        x.op = m_op; x.tgt = m_tgt; x.dep = DW'(m_stk.size()); x.err = m_err;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        o.op = op; o.tgt = tgt_out; o.dep = dep; o.err = err;
    endtask

    task automatic go_run();
        obs_t e, o;
        cyc(1'b0, 1'b0, C_STEP, '0, '0, e, o);
        cyc(1'b1, 1'b0, C_STEP, '0, '0, e, o);
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, C_JUMP, 16'h1234, '0, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_sb: got %s exp %s", fmt(o), fmt(e)); end
        end
        checks++;
        if (op !== 2'b00 || tgt_out !== 16'h0 || dep !== '0 || err !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL reset_state: got op=%0d tgt=%h dep=%0d err=%0b rdy=%0b exp 0/0/0/0/0",
                               op, tgt_out, dep, err, ready);
        end
    endtask

    task automatic test_step();
        obs_t e, o;
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, i != 0, C_STEP, '0, '0, e, o);
            checks++;
            if (o !== e || o.op !== seq[i]) begin
                errors++; $display("FAIL step_%0d: got %s exp %s op=%0d", i, fmt(o), fmt(e), seq[i]);
            end
        end
        cyc(1'b1, 1'b0, C_STEP, '0, '0, e, o);
        checks++;
        if (pc_r !== 16'h000C) begin errors++; $display("FAIL step_pc: got %h exp 000c", pc_r); end
    endtask

    task automatic test_call_ret();
        obs_t e, o;
        cyc(1'b1, 1'b1, C_JUMP, 16'h0040, 16'h0010, e, o);
        checks++;
        if (o !== e || o.op !== 2'b11 || o.tgt !== 16'h0040) begin
            errors++; $display("FAIL jump: got %s exp %s", fmt(o), fmt(e));
        end
        cyc(1'b1, 1'b1, C_CALL, 16'h0100, 16'h0044, e, o);
        checks++;
        if (o !== e || o.dep !== DW'(1) || o.tgt !== 16'h0100) begin
            errors++; $display("FAIL call: got %s exp %s", fmt(o), fmt(e));
        end
        cyc(1'b1, 1'b1, C_RET, 16'h0000, 16'h0104, e, o);
        checks++;
        if (o !== e || o.op !== 2'b11 || o.tgt !== 16'h0044 || o.dep !== '0) begin
            errors++; $display("FAIL ret: got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_overflow();
        obs_t e, o;
        go_run();
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, C_CALL, 16'h0200 + 16'(i * 16), 16'h1000 + 16'(i * 4), e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL ovf_call_%0d: got %s exp %s", i, fmt(o), fmt(e)); end
        end
        checks++;
        if (o.op !== 2'b01 || o.err !== 1'b1 || o.dep !== DW'(8)) begin
            errors++; $display("FAIL ovf_9th: got %s exp op=1 err=1 dep=8", fmt(o));
        end
        cyc(1'b1, 1'b1, C_STEP, '0, '0, e, o);
        checks++;
        if (o !== e || o.op !== 2'b01 || o.rdy !== 1'b1) begin
            errors++; $display("FAIL err_step: got %s exp %s", fmt(o), fmt(e));
        end
        cyc(1'b1, 1'b1, C_RESTART, '0, '0, e, o);
        checks++;
        if (o !== e || o.op !== 2'b00 || o.dep !== '0 || o.err !== 1'b0) begin
            errors++; $display("FAIL err_restart: got %s exp %s", fmt(o), fmt(e));
        end
        cyc(1'b1, 1'b1, C_STEP, '0, '0, e, o);
        checks++;
        if (o !== e || o.op !== 2'b10) begin errors++; $display("FAIL post_restart: got %s exp %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_underflow();
        obs_t e, o;
        go_run();
        cyc(1'b1, 1'b1, C_RET, '0, 16'h0008, e, o);
        checks++;
        if (o !== e || o.err !== 1'b1 || o.op !== 2'b01) begin
            errors++; $display("FAIL underflow: got %s exp %s", fmt(o), fmt(e));
        end
        cyc(1'b1, 1'b1, C_JUMP, 16'h0080, '0, e, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL err_jump_ignored: got %s exp %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_idle_midreset();
        obs_t e, o;
        go_run();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, C_CALL, 16'h0300 + 16'(i * 8), 16'h0020 + 16'(i * 4), e, o);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, C_CALL, 16'hFFFC, '0, e, o);
            checks++;
            if (o !== e || o.op !== 2'b01 || o.tgt !== 16'h0310 || o.dep !== DW'(3)) begin
                errors++; $display("FAIL idle_%0d: got %s exp %s", i, fmt(o), fmt(e));
            end
        end
        cyc(1'b0, 1'b1, C_RET, '0, '0, e, o);
        checks++;
        if (o !== e || o.dep !== '0 || o.op !== 2'b00) begin
            errors++; $display("FAIL midreset: got %s exp %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_align();
        obs_t e, o;
        go_run();
        cyc(1'b1, 1'b1, C_JUMP, 16'h0042, '0, e, o);
        checks++;
        if (o !== e) begin errors++; $display("FAIL align_sb: got %s exp %s", fmt(o), fmt(e)); end
        checks++;
        if (ALN ? (o.err !== 1'b1 || o.op !== 2'b01) : (o.op !== 2'b11 || o.tgt !== 16'h0042)) begin
            errors++; $display("FAIL align_jump: got %s (align check %0b)", fmt(o), ALN);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        logic [2:0] c;
        logic [ANCHO-1:0] t;
        go_run();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, C_CALL, 16'h0400 + 16'(i * 4), 16'h0500 + 16'(i * 4), e, o);
            cyc(1'b1, 1'b1, C_RET, '0, '0, e, o);
            checks++;
            if (o !== e || o.tgt !== 16'h0500 + 16'(i * 4)) begin
                errors++; $display("FAIL call_ret_%0d: got %s exp %s", i, fmt(o), fmt(e));
            end
        end
        for (int i = 0; i < 120; i++) begin
            c = 3'($urandom_range(0, 7));
            if (c == C_RESTART && $urandom_range(0, 3) != 0) c = C_CALL;
            t = 16'($urandom);
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            cyc(1'b1, $urandom_range(0, 4) != 0, c, t, 16'($urandom) & 16'hFFFC, e, o);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rand_%0d cmd=%0d: got %s exp %s", i, c, fmt(o), fmt(e)); end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_idle_midreset();
        test_align();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
